// File: rtl/mult_sequencer.sv
// Control FSM for the 8-bit signed shift-add multiplier datapath.
// Define SEQ_DEBOUNCE_EN to add a per-button debounce filter.
module mult_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ITERATIONS      = 8,
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          ClearA_LoadB,
    input  logic          M,
    output logic          Clr_Ld,
    output logic          Clr_A,
    output logic          Ld_A,
    output logic          Add,
    output logic          Sub,
    output logic          Shift,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Count
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ADD,
        SHIFT,
        HOLD
    } state_e;

    localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

    // Bit 0 is Run, bit 1 is ClearA_LoadB; all levels are active-low.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] acc;
    logic [1:0] acc_prev_q;
    logic [1:0] fell;
    logic       run_evt;
    logic       clr_evt;

    assign btn_raw = {ClearA_LoadB, Run};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            acc_prev_q <= '1;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            acc_prev_q <= acc;
        end
    end

`ifdef SEQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    acc_q;
    logic [1:0]    acc_d;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];

    // Any cycle that matches the accepted level restarts the count.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != acc_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    acc_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc_q       <= '1;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            acc_q       <= acc_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    assign acc = acc_q;
`else
    assign acc = sync2_q;
`endif

    assign fell    = acc_prev_q & ~acc;
    assign run_evt = fell[0];
    assign clr_evt = fell[1];

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          last;

    assign last  = (count_q == LAST);
    assign Count = count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE:  if (run_evt) state_d = CLEAR;
            CLEAR: begin
                count_d = '0;
                state_d = ADD;
            end
            ADD:   state_d = SHIFT;
            SHIFT: begin
                if (last) begin
                    state_d = HOLD;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = ADD;
                end
            end
            HOLD:  if (acc[0]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // The final iteration subtracts: the multiplier MSB has negative weight.
    always_comb begin
        Clr_Ld = 1'b0;
        Clr_A  = 1'b0;
        Ld_A   = 1'b0;
        Add    = 1'b0;
        Sub    = 1'b0;
        Shift  = 1'b0;
        Busy   = 1'b0;
        Done   = 1'b0;
        unique case (state_q)
            IDLE:  Clr_Ld = clr_evt & ~run_evt;
            CLEAR: begin
                Clr_A = 1'b1;
                Busy  = 1'b1;
            end
            ADD:   begin
                Busy = 1'b1;
                Ld_A = M;
                Add  = M & ~last;
                Sub  = M & last;
            end
            SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
            end
            HOLD:  Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural X:A:B datapath.
// Build with SEQ_DEBOUNCE_EN defined to also cover the debounce filter.
module tb_mult_sequencer;

    localparam int DB    = 4;
    localparam int PRESS = 6;
`ifdef SEQ_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Run = 1'b1;
    logic       ClearA_LoadB = 1'b1;
    logic       M;
    logic       Clr_Ld, Clr_A, Ld_A, Add, Sub, Shift, Busy, Done;
    logic [2:0] Count;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;
    int m_sel = 1;

    int n_clr_ld = 0, n_clr_a = 0, n_ld = 0;
    int n_add = 0, n_sub = 0, n_shift = 0;
    int b_clr_ld, b_clr_a, b_ld, b_add, b_sub, b_shift;

    logic       x_m = 1'b0;
    logic [7:0] a_m = '0;
    logic [7:0] b_m = '0;
    logic [7:0] sw = '0;
    logic [7:0] s_val = '0;
    logic [8:0] sum;
    logic [15:0] exp_q [$];

    logic [7:0] b_tab [3];
    logic [7:0] s_tab [3];

    mult_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .ITERATIONS     (8)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Run         (Run),
        .ClearA_LoadB(ClearA_LoadB),
        .M           (M),
        .Clr_Ld      (Clr_Ld),
        .Clr_A       (Clr_A),
        .Ld_A        (Ld_A),
        .Add         (Add),
        .Sub         (Sub),
        .Shift       (Shift),
        .Busy        (Busy),
        .Done        (Done),
        .Count       (Count)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    assign M    = (m_sel == 2) ? b_m[0] : (m_sel == 1);
    assign outs = {Clr_Ld, Clr_A, Ld_A, Add, Sub, Shift, Busy, Done};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic snap();
        b_clr_ld = n_clr_ld;
        b_clr_a  = n_clr_a;
        b_ld     = n_ld;
        b_add    = n_add;
        b_sub    = n_sub;
        b_shift  = n_shift;
    endtask

    function automatic bit hit(input int sel, input int target);
        case (sel)
            0:       return Clr_A === 1'b1;
            1:       return Done === 1'b1;
            default: return (n_shift - b_shift) >= target;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int target,
                              input int budget, input string tag);
        int k;
        k = 0;
        while (!hit(sel, target) && k < budget) begin
            step();
            k++;
        end
        chk(tag, hit(sel, target), 1);
    endtask

    task automatic do_mult(input bit hold);
        Run = 1'b0;
        wait_until(0, 0, 30, "clear_wait");
        t0 = cyc;
        if (!hold) Run = 1'b1;
        wait_until(1, 0, 40, "done_wait");
        chk("latency", cyc - t0, 17);
        chk("busy_in_hold", Busy, 0);
    endtask

    task automatic settle();
        repeat (LAT + 2) step();
    endtask

    // Datapath model driven by the DUT's control outputs.
    always @(negedge Clk) begin
        if (Reset) begin
            if (Clr_Ld) begin
                x_m      <= 1'b0;
                a_m      <= '0;
                b_m      <= sw;
                n_clr_ld <= n_clr_ld + 1;
            end
            if (Clr_A) begin
                x_m     <= 1'b0;
                a_m     <= '0;
                n_clr_a <= n_clr_a + 1;
            end
            if (Ld_A) begin
                sum = Sub ? {a_m[7], a_m} - {s_val[7], s_val}
                          : {a_m[7], a_m} + {s_val[7], s_val};
                x_m  <= sum[8];
                a_m  <= sum[7:0];
                n_ld <= n_ld + 1;
            end
            if (Add) n_add <= n_add + 1;
            if (Sub) begin
                n_sub <= n_sub + 1;
                chk("sub_on_last", Count, 7);
            end
            if (Shift) begin
                a_m     <= {x_m, a_m[7:1]};
                b_m     <= {a_m[0], b_m[7:1]};
                n_shift <= n_shift + 1;
            end
            if (Add | Sub | Ld_A)
                chk("ld_op", {Add & Sub, Ld_A}, {1'b0, Add | Sub});
        end
    end

    initial begin
        int p;
        b_tab[0] = 8'hF9; s_tab[0] = 8'h03;
        b_tab[1] = 8'h05; s_tab[1] = 8'hFD;
        b_tab[2] = 8'h80; s_tab[2] = 8'h80;

        step();
        step();
        chk("reset_outs", outs, 0);
        chk("reset_count", Count, 0);
        Reset = 1'b1;
        step();
        step();
        chk("idle_outs", outs, 0);

        m_sel = 1;
        snap();
        do_mult(0);
        chk("m1_clr_a", n_clr_a - b_clr_a, 1);
        chk("m1_add", n_add - b_add, 7);
        chk("m1_ld", n_ld - b_ld, 8);
        chk("m1_sub", n_sub - b_sub, 1);
        chk("m1_shift", n_shift - b_shift, 8);
        chk("m1_count_hold", Count, 7);
        settle();
        chk("m1_idle", outs, 0);

        m_sel = 0;
        snap();
        do_mult(0);
        chk("m0_ld", n_ld - b_ld, 0);
        chk("m0_add", n_add - b_add, 0);
        chk("m0_sub", n_sub - b_sub, 0);
        chk("m0_shift", n_shift - b_shift, 8);
        settle();

        m_sel = 2;
        for (int i = 0; i < 3; i++) begin
            sw    = b_tab[i];
            s_val = s_tab[i];
            snap();
            ClearA_LoadB = 1'b0;
            repeat (PRESS) step();
            ClearA_LoadB = 1'b1;
            settle();
            chk("load_pulse", n_clr_ld - b_clr_ld, 1);
            chk("load_b", b_m, sw);
            p = $signed(sw) * $signed(s_val);
            exp_q.push_back(p[15:0]);
            do_mult(0);
            if (exp_q.size() > 0)
                chk("product", {a_m, b_m}, exp_q.pop_front());
            settle();
        end

        m_sel = 0;
        snap();
        do_mult(1);
        repeat (10) step();
        chk("hold_done", Done, 1);
        chk("hold_no_reclear", n_clr_a - b_clr_a, 1);
        Run = 1'b1;
        repeat (LAT) step();
        chk("hold_before_release", Done, 1);
        step();
        chk("idle_after_release", outs, 0);
        do_mult(0);
        chk("rerun_clear", n_clr_a - b_clr_a, 2);
        settle();

        snap();
        ClearA_LoadB = 1'b0;
        repeat (20) step();
        ClearA_LoadB = 1'b1;
        settle();
        chk("held_clr_ld", n_clr_ld - b_clr_ld, 1);
        chk("held_no_clear", n_clr_a - b_clr_a, 0);

        m_sel = 1;
        snap();
        Run = 1'b0;
        wait_until(0, 0, 30, "clear_wait");
        Run = 1'b1;
        wait_until(2, 1, 10, "shift_wait");
        ClearA_LoadB = 1'b0;
        repeat (8) step();
        ClearA_LoadB = 1'b1;
        wait_until(1, 0, 40, "done_wait");
        settle();
        chk("busy_clr_ld", n_clr_ld - b_clr_ld, 0);

        snap();
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        wait_until(0, 0, 30, "both_clear");
        Run = 1'b1;
        ClearA_LoadB = 1'b1;
        wait_until(1, 0, 40, "done_wait");
        settle();
        chk("both_clr_ld", n_clr_ld - b_clr_ld, 0);
        chk("both_clr_a", n_clr_a - b_clr_a, 1);

        snap();
        Run = 1'b0;
        wait_until(0, 0, 30, "clear_wait");
        Run = 1'b1;
        wait_until(2, 5, 20, "shift5_wait");
        @(posedge Clk);
        #1;
        chk("pre_reset_ld", {Ld_A, Add}, 2'b11);
        Reset = 1'b0;
        #1;
        chk("async_reset_outs", outs, 0);
        chk("async_reset_count", Count, 0);
        step();
        Reset = 1'b1;
        repeat (LAT + 4) step();
        chk("post_reset_idle", outs, 0);
        chk("post_reset_no_clear", n_clr_a - b_clr_a, 1);

`ifdef SEQ_DEBOUNCE_EN
        snap();
        Run = 1'b0;
        repeat (3) step();
        Run = 1'b1;
        repeat (15) step();
        chk("glitch_no_clear", n_clr_a - b_clr_a, 0);
        Run = 1'b0;
        repeat (6) step();
        Run = 1'b1;
        wait_until(0, 0, 10, "debounced_clear");
        wait_until(1, 0, 40, "done_wait");
        settle();
        chk("debounced_one_clear", n_clr_a - b_clr_a, 1);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
